pipeline_hazard_controller: RTL

PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

---
 rtl/pipeline_hazard_controller.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_controller.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_controller
//
// Purpose:
//   Hazard and stall controller for a classic 5-stage in-order pipeline.
//   It resolves memory-busy holds, taken-branch and jump flushes, and load-use
//   stalls in a fixed priority. It also keeps saturating performance counters
//   and raises a sticky error when the data memory stays busy too long.
//
// Parameters:
//   CNT_W   - width of the Stall_Cycles / Flush_Events counters
//   TIMEOUT - consecutive Mem_Busy cycles after which Mem_Timeout sets
//
// Ports:
//   clk              in   clock, all state updates on the rising edge
//   reset            in   synchronous active-high reset
//   ID_Rs, ID_Rt     in   [4:0] source registers of the instruction in ID
//   ID_Uses_Rt       in   ID instruction actually reads Rt
//   ID_Jump          in   jump decoded in ID
//   ID_EX_MemRead    in   instruction in EX is a load
//   ID_EX_Rt         in   [4:0] load destination register
//   EX_Branch_Taken  in   branch resolved taken in EX
//   Mem_Busy         in   data memory not ready
//   PC_Write         out  1 = PC updates
//   IF_ID_Write      out  1 = IF/ID captures
//   IF_ID_Flush      out  clear IF/ID
//   ID_EX_Bubble     out  insert NOP into ID/EX
//   EX_MEM_Hold      out  freeze EX/MEM and later stages
//   Mem_Timeout      out  sticky memory-timeout error
//   Stall_Cycles     out  [CNT_W-1:0] cycles with PC_Write=0 (saturating)
//   Flush_Events     out  [CNT_W-1:0] branch/jump flushes (saturating)
// -----------------------------------------------------------------------------
module pipeline_hazard_controller #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ID_Rs,
  input  logic [4:0]       ID_Rt,
  input  logic             ID_Uses_Rt,
  input  logic             ID_Jump,
  input  logic             ID_EX_MemRead,
  input  logic [4:0]       ID_EX_Rt,
  input  logic             EX_Branch_Taken,
  input  logic             Mem_Busy,
  output logic             PC_Write,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Bubble,
  output logic             EX_MEM_Hold,
  output logic             Mem_Timeout,
  output logic [CNT_W-1:0] Stall_Cycles,
  output logic [CNT_W-1:0] Flush_Events
);

  // The busy counter only ever needs to reach TIMEOUT, where it parks.
  localparam int BUSY_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [BUSY_W:0] TIMEOUT_V = (BUSY_W + 1)'(TIMEOUT);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    FLUSH      = 2'd2,
    MEM_WAIT   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic [CNT_W-1:0]  flush_q, flush_d;
  logic [BUSY_W-1:0] busy_cnt_q, busy_cnt_d;
  logic              timeout_q, timeout_d;
  logic [BUSY_W:0]   busy_inc;
  logic              load_use;
  logic              flush_event;

  // Register 0 is hard-wired zero, so a load targeting it never creates a hazard.
  assign load_use = ID_EX_MemRead && (ID_EX_Rt != 5'd0) &&
                    ((ID_EX_Rt == ID_Rs) || (ID_Uses_Rt && (ID_EX_Rt == ID_Rt)));

  // Next-state and control outputs. Defaults describe a free-running pipeline,
  // which is also what the pipeline sees while reset is asserted.
  always_comb begin
    state_d      = RUN;
    PC_Write     = 1'b1;
    IF_ID_Write  = 1'b1;
    IF_ID_Flush  = 1'b0;
    ID_EX_Bubble = 1'b0;
    EX_MEM_Hold  = 1'b0;
    flush_event  = 1'b0;
    if (!reset) begin
      if (Mem_Busy) begin
        // Whole pipeline freezes; nothing is flushed or bubbled while frozen,
        // so a pending branch/jump/load-use is simply re-seen afterwards.
        PC_Write    = 1'b0;
        IF_ID_Write = 1'b0;
        EX_MEM_Hold = 1'b1;
        state_d     = MEM_WAIT;
      end else if (EX_Branch_Taken) begin
        IF_ID_Flush  = 1'b1;
        ID_EX_Bubble = 1'b1;
        flush_event  = 1'b1;
        state_d      = FLUSH;
      end else if (ID_Jump && (state_q != FLUSH)) begin
        // In FLUSH the ID stage holds a squashed instruction, so its decode is stale.
        IF_ID_Flush = 1'b1;
        flush_event = 1'b1;
        state_d     = FLUSH;
      end else if (load_use && ((state_q == RUN) || (state_q == MEM_WAIT))) begin
        // LOAD_STALL is excluded so each load-use costs exactly one bubble.
        PC_Write     = 1'b0;
        IF_ID_Write  = 1'b0;
        ID_EX_Bubble = 1'b1;
        state_d      = LOAD_STALL;
      end
    end
  end

  // Counters and timeout tracking.
  always_comb begin
    stall_d = stall_q;
    if (!PC_Write && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end

    flush_d = flush_q;
    if (flush_event && (flush_q != {CNT_W{1'b1}})) begin
      flush_d = flush_q + CNT_W'(1);
    end

    busy_inc   = {1'b0, busy_cnt_q} + (BUSY_W + 1)'(1);
    busy_cnt_d = '0;
    timeout_d  = timeout_q;
    if (Mem_Busy) begin
      if (busy_inc >= TIMEOUT_V) begin
        busy_cnt_d = TIMEOUT_V[BUSY_W-1:0];
        timeout_d  = 1'b1;
      end else begin
        busy_cnt_d = busy_inc[BUSY_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      stall_q    <= '0;
      flush_q    <= '0;
      busy_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      stall_q    <= stall_d;
      flush_q    <= flush_d;
      busy_cnt_q <= busy_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign Mem_Timeout  = timeout_q;
  assign Stall_Cycles = stall_q;
  assign Flush_Events = flush_q;

endmodule
